// File: rtl/aes_state_mux.sv
// aes_state_mux: selects one of CHANNELS input words (fixed select or
// round-robin among valid channels) into a single-entry registered output.
//
// Handshake: a word moves across any valid/ready pair on the rising edge
// where both valid and ready are high. Ready never depends on that same
// channel's valid in fixed mode. In round-robin mode, ready is raised only
// on the granted channel. Valid must hold its word until ready is seen.
module aes_state_mux #(
  parameter int WIDTH    = 128,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      rr_mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  // Output register and round-robin pointer
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_chan_q,  out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

  // Combinational selection signals
  logic                space;
  logic                sel_ok;
  logic [SEL_W:0]      rr_idx [CHANNELS];
  logic [CHANNELS-1:0] rr_hit;
  logic                rr_any;
  logic [SEL_W-1:0]    rr_grant;
  logic [SEL_W-1:0]    xfer_chan;
  logic                xfer;
  logic [WIDTH-1:0]    xfer_data;
  logic [SEL_W-1:0]    rr_next;

  // The output slot can take a word if it is empty or is being drained now.
  assign space = !out_valid_q || out_ready;

  // A select at or beyond CHANNELS addresses no channel at all.
  assign sel_ok = ({1'b0, sel} < (SEL_W+1)'(CHANNELS));

  // Search position g is channel (rr_ptr + g) mod CHANNELS. rr_ptr and g are
  // both below CHANNELS, so a single conditional subtract performs the wrap.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_rr
    logic [SEL_W:0] sum;
    assign sum       = {1'b0, rr_ptr_q} + (SEL_W+1)'(g);
    assign rr_idx[g] = (sum >= (SEL_W+1)'(CHANNELS)) ? (sum - (SEL_W+1)'(CHANNELS)) : sum;
    assign rr_hit[g] = in_valid[rr_idx[g][SEL_W-1:0]];
  end

  assign rr_any = |rr_hit;

  // Round-robin grant: the earliest valid channel at or after rr_ptr.
  always_comb begin
    rr_grant = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rr_hit[i]) rr_grant = rr_idx[i][SEL_W-1:0];
    end
  end

  // Per-channel ready: at most one bit set, and none while in reset.
  always_comb begin
    in_ready = '0;
    if (!rst && space) begin
      if (rr_mode) begin
        if (rr_any) in_ready[rr_grant] = 1'b1;
      end else if (sel_ok) begin
        in_ready[sel] = 1'b1;
      end
    end
  end

  assign xfer      = |(in_valid & in_ready);
  assign xfer_chan = rr_mode ? rr_grant : sel;

  // Data mux for the channel that is transferring this cycle.
  always_comb begin
    xfer_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (xfer_chan == SEL_W'(k)) xfer_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Pointer after a round-robin grant: one past the winner, wrapping at CHANNELS-1.
  assign rr_next = ({1'b0, rr_grant} == (SEL_W+1)'(CHANNELS - 1)) ? '0 : rr_grant + 1'b1;

  // Next-state for the output slot and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = xfer_data;
      out_chan_d  = xfer_chan;
      out_valid_d = 1'b1;
      if (rr_mode) rr_ptr_d = rr_next;
    end else if (out_ready) begin
      // Drained with nothing to replace it: data and channel keep their last value.
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule
